// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - opcode/funct3 constants, LSU state encoding and decode helpers
package lsu_ctrl_pkg;

  localparam logic [6:0] opcode_load  = 7'b0000011;
  localparam logic [6:0] opcode_store = 7'b0100011;

  localparam logic [2:0] f3_lb  = 3'b000;
  localparam logic [2:0] f3_lh  = 3'b001;
  localparam logic [2:0] f3_lw  = 3'b010;
  localparam logic [2:0] f3_lbu = 3'b100;
  localparam logic [2:0] f3_lhu = 3'b101;
  localparam logic [2:0] f3_sb  = 3'b000;
  localparam logic [2:0] f3_sh  = 3'b001;
  localparam logic [2:0] f3_sw  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_e;

  function automatic logic legal_f3(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return f3 inside {f3_lb, f3_lh, f3_lw, f3_lbu, f3_lhu};
    return f3 inside {f3_sb, f3_sh, f3_sw};
  endfunction

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data-memory request/ready bus between the LSU and memory
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load lane extract/extend
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    case (st_funct3_i)
      f3_sb: begin
        st_be_o   = 4'b0001 << st_addr_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      f3_sh: begin
        st_be_o   = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
    ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      f3_lb:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      f3_lh:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      f3_lbu:  ld_data_o = {24'h0, ld_byte};
      f3_lhu:  ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store sequencer: decode, bus handshake, stall, fault and timeout
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  lsu_ctrl_if.master        mem,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              fault_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_addr_q, ld_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              fault_q, fault_d;

  logic        is_load, is_store, op_ok, op_bad, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_ext;

  assign is_load     = opcode_i == opcode_load;
  assign is_store    = opcode_i == opcode_store;
  assign op_ok       = (is_load || is_store) && legal_f3(is_load, funct3_i)
                       && !misaligned(funct3_i, addr_i[1:0]);
  assign op_bad      = (is_load || is_store) && !op_ok;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .st_funct3_i (funct3_i),
    .st_addr_i   (addr_i[1:0]),
    .st_data_i   (wdata_i),
    .st_be_o     (st_be),
    .st_data_o   (st_data),
    .ld_funct3_i (ld_f3_q),
    .ld_addr_i   (ld_addr_q),
    .ld_rdata_i  (mem.mem_rdata),
    .ld_data_o   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      is_load_q    <= 1'b0;
      ld_f3_q      <= '0;
      ld_addr_q    <= '0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      is_load_q    <= is_load_d;
      ld_f3_q      <= ld_f3_d;
      ld_addr_q    <= ld_addr_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (op_ok) state_d = LSU_ACCESS;
      LSU_ACCESS: if (mem.mem_ready || timeout_hit) state_d = LSU_DONE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  // Bus registers only change in IDLE, which keeps them stable for the whole request
  always_comb begin
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    is_load_d    = is_load_q;
    ld_f3_d      = ld_f3_q;
    ld_addr_d    = ld_addr_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (op_ok) begin
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {addr_i[31:2], 2'b00};
          be_d      = is_store ? st_be : 4'b1111;
          wdata_d   = st_data;
          is_load_d = is_load;
          ld_f3_d   = funct3_i;
          ld_addr_d = addr_i[1:0];
          cnt_d     = '0;
        end else if (op_bad) begin
          fault_d = 1'b1;
        end
      end
      LSU_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_ready) begin
          req_d = 1'b0;
          if (is_load_q) begin
            load_data_d  = ld_ext;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Gated by rst_n so every output reads 0 while reset is held
  assign stall_o = rst_n && ((state_q == LSU_ACCESS) || ((state_q == LSU_IDLE) && op_ok));

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign load_data_o   = load_data_q;
  assign load_valid_o  = load_valid_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl against a behavioural LSU model
module tb_lsu_ctrl;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] NOP = 7'b0010011;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        fault_o;

  lsu_ctrl_if mem_if ();

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .mem          (mem_if),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  op_t         op_q[$];
  int          obs_stall, obs_req, obs_lv, obs_fault, obs_cycles;
  bit          obs_unstable, obs_hung;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_be;
  logic        obs_we;

  function automatic bit m_is_mem(op_t o);
    return o.opc == LD || o.opc == ST;
  endfunction

  function automatic int m_size(op_t o);
    return 1 << (o.f3 % 4);
  endfunction

  function automatic bit m_fault(op_t o);
    bit legal;
    if (o.opc == LD) legal = o.f3 inside {0, 1, 2, 4, 5};
    else if (o.opc == ST) legal = o.f3 <= 2;
    else return 1'b0;
    if (!legal) return 1'b1;
    return (o.addr % m_size(o)) != 0;
  endfunction

  function automatic logic [3:0] m_be(op_t o);
    int tmp;
    if (o.opc == LD) return 4'hF;
    tmp = ((1 << m_size(o)) - 1) << (o.addr % 4);
    return tmp[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(op_t o);
    case (m_size(o))
      1:       return {24'h0, o.wdata[7:0]} * 32'h01010101;
      2:       return {16'h0, o.wdata[15:0]} * 32'h00010001;
      default: return o.wdata;
    endcase
  endfunction

  function automatic logic [31:0] m_load(op_t o);
    int          n;
    logic [31:0] v, mask;
    n    = m_size(o);
    v    = o.rdata >> (8 * (o.addr % 4));
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v    = v & mask;
    if (o.f3 < 4 && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic op_t mk(logic [6:0] opc, logic [2:0] f3, logic [31:0] addr,
                             logic [31:0] wdata, logic [31:0] rdata, int waits);
    op_t o;
    o.opc = opc; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.waits = waits;
    return o;
  endfunction

  task automatic present(op_t o);
    opcode_i = o.opc;
    funct3_i = o.f3;
    addr_i   = o.addr;
    wdata_i  = o.wdata;
  endtask

  // Plays op_q as a pipeline would: each op is held until a cycle with stall_o low
  task automatic run_ops();
    int idx = 0, acc = 0, tail = 0, cyc = 0;
    bit retire;
    obs_stall = 0; obs_req = 0; obs_lv = 0; obs_fault = 0; obs_cycles = 0;
    obs_unstable = 0; obs_hung = 0;
    @(posedge clk); #1;
    present(op_q[0]);
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_o) obs_stall++;
      if (load_valid_o) begin obs_lv++; obs_ld = load_data_o; end
      if (fault_o) obs_fault++;
      if (mem_if.mem_req) begin
        acc++;
        obs_req++;
        if (acc == 1) begin
          obs_addr = mem_if.mem_addr; obs_be = mem_if.mem_be;
          obs_we = mem_if.mem_we; obs_wdata = mem_if.mem_wdata;
        end else if (obs_addr !== mem_if.mem_addr || obs_be !== mem_if.mem_be ||
                     obs_we !== mem_if.mem_we || obs_wdata !== mem_if.mem_wdata) begin
          obs_unstable = 1;
        end
      end
      retire = (idx < op_q.size()) && !stall_o;
      if (idx < op_q.size() && mem_if.mem_req && op_q[idx].waits >= 0 && acc == op_q[idx].waits + 1) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = op_q[idx].rdata;
      end else begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = $urandom;
      end
      if (retire && idx == op_q.size() - 1) obs_cycles = cyc;
      @(posedge clk); #1;
      if (retire) begin
        idx++;
        acc = 0;
        if (idx < op_q.size()) present(op_q[idx]);
        else opcode_i = NOP;
      end
      if (idx >= op_q.size()) tail++;
      if (tail >= 3) break;
      if (cyc > 100) begin obs_hung = 1; break; end
    end
    mem_if.mem_ready = 1'b0;
    opcode_i = NOP;
  endtask

  task automatic test_reset();
    present(mk(LD, 3'd2, 32'h40, 32'h0, 32'h0, 0));
    #12;
    n_checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_be, stall_o, load_valid_o, fault_o} !== 9'h0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be, stall_o, load_valid_o, fault_o});
    end
    n_checks++;
    if ({mem_if.mem_addr, mem_if.mem_wdata, load_data_o} !== 96'h0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0",
        {mem_if.mem_addr, mem_if.mem_wdata, load_data_o});
    end
    opcode_i = NOP;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_basic();
    op_q = '{mk(ST, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0)};
    run_ops();
    n_checks++; if (obs_hung !== 0) begin n_errors++; $display("FAIL sw_hang: got %0d expected 0", obs_hung); end
    n_checks++; if (obs_req !== 1) begin n_errors++; $display("FAIL sw_req_cycles: got %0d expected 1", obs_req); end
    n_checks++; if (obs_stall !== 2) begin n_errors++; $display("FAIL sw_stall: got %0d expected 2", obs_stall); end
    n_checks++;
    if ({obs_addr, obs_be, obs_we, obs_wdata} !== {32'h100, 4'hF, 1'b1, 32'hDEADBEEF}) begin
      n_errors++; $display("FAIL sw_bus: got addr %h be %b we %b wdata %h expected 100 1111 1 deadbeef",
        obs_addr, obs_be, obs_we, obs_wdata);
    end
    n_checks++; if (obs_lv !== 0 || obs_fault !== 0) begin
      n_errors++; $display("FAIL sw_pulses: got lv %0d fault %0d expected 0 0", obs_lv, obs_fault); end
  endtask

  task automatic test_lb_wait();
    op_q = '{mk(LD, 3'd0, 32'h203, 32'h0, 32'h80FF_FF12, 3)};
    run_ops();
    n_checks++; if (obs_ld !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_data: got %h expected ffffff80", obs_ld); end
    n_checks++; if (obs_lv !== 1) begin n_errors++; $display("FAIL lb_valid: got %0d expected 1", obs_lv); end
    n_checks++; if (obs_stall !== 5) begin n_errors++; $display("FAIL lb_stall: got %0d expected 5", obs_stall); end
    n_checks++; if (obs_fault !== 0 || obs_unstable !== 0) begin
      n_errors++; $display("FAIL lb_fault_stable: got fault %0d unstable %0d expected 0 0", obs_fault, obs_unstable); end
    n_checks++; if (obs_addr !== 32'h200 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      n_errors++; $display("FAIL lb_bus: got %h %b %b expected 200 1111 0", obs_addr, obs_be, obs_we); end
  endtask

  task automatic test_lhu_sb();
    op_q = '{mk(LD, 3'd5, 32'h202, 32'h0, 32'h8001_0000, 1)};
    run_ops();
    n_checks++; if (obs_ld !== 32'h00008001) begin n_errors++; $display("FAIL lhu_data: got %h expected 00008001", obs_ld); end
    op_q = '{mk(ST, 3'd0, 32'h301, 32'h0000_00AB, 32'h0, 0)};
    run_ops();
    n_checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hABABABAB || obs_addr !== 32'h300) begin
      n_errors++; $display("FAIL sb_lanes: got be %b wdata %h addr %h expected 0010 abababab 300",
        obs_be, obs_wdata, obs_addr); end
  endtask

  task automatic test_faults();
    op_t o[2];
    o[0] = mk(LD, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    o[1] = mk(LD, 3'd3, 32'h100, 32'h0, 32'h0, 0);
    foreach (o[i]) begin
      op_q = '{o[i]};
      run_ops();
      n_checks++; if (obs_fault !== 1 || obs_req !== 0 || obs_stall !== 0 || obs_lv !== 0) begin
        n_errors++; $display("FAIL fault_%0d: got fault %0d req %0d stall %0d lv %0d expected 1 0 0 0",
          i, obs_fault, obs_req, obs_stall, obs_lv); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    rd = $urandom;
    op_q = '{mk(LD, 3'd2, 32'h500, 32'h0, 32'h0, -1), mk(LD, 3'd2, 32'h504, 32'h0, rd, 0)};
    run_ops();
    n_checks++; if (obs_hung !== 0) begin n_errors++; $display("FAIL to_hang: got %0d expected 0", obs_hung); end
    n_checks++; if (obs_req !== 5) begin n_errors++; $display("FAIL to_req_cycles: got %0d expected 5", obs_req); end
    n_checks++; if (obs_fault !== 1) begin n_errors++; $display("FAIL to_fault: got %0d expected 1", obs_fault); end
    n_checks++; if (obs_lv !== 1 || obs_ld !== rd) begin
      n_errors++; $display("FAIL to_next_load: got lv %0d data %h expected 1 %h", obs_lv, obs_ld, rd); end
    n_checks++; if (obs_stall !== 7) begin n_errors++; $display("FAIL to_stall: got %0d expected 7", obs_stall); end
  endtask

  task automatic test_back_to_back();
    op_q = '{mk(LD, 3'd2, 32'h600, 32'h0, 32'h1234_5678, 0),
             mk(LD, 3'd1, 32'h602, 32'h0, 32'h9ABC_0000, 1),
             mk(ST, 3'd1, 32'h604, 32'h0000_5A5A, 32'h0, 0)};
    run_ops();
    n_checks++; if (obs_cycles !== 10) begin n_errors++; $display("FAIL b2b_cycles: got %0d expected 10", obs_cycles); end
    n_checks++; if (obs_stall !== 7) begin n_errors++; $display("FAIL b2b_stall: got %0d expected 7", obs_stall); end
    n_checks++; if (obs_lv !== 2) begin n_errors++; $display("FAIL b2b_valid: got %0d expected 2", obs_lv); end
    n_checks++; if (load_data_o !== 32'hFFFF9ABC) begin
      n_errors++; $display("FAIL b2b_hold: got %h expected ffff9abc", load_data_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    @(posedge clk); #1;
    present(mk(LD, 3'd2, 32'h40, 32'h0, 32'h0, 0));
    mem_if.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mem_if.mem_req !== 1'b1) begin n_errors++; $display("FAIL rstmid_req_before: got %b expected 1", mem_if.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_if.mem_req !== 1'b0 || stall_o !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_async: got req %b stall %b expected 0 0", mem_if.mem_req, stall_o); end
    opcode_i = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    rd = $urandom;
    op_q = '{mk(LD, 3'd2, 32'h44, 32'h0, rd, 1)};
    run_ops();
    n_checks++; if (obs_lv !== 1 || obs_ld !== rd || obs_req !== 2 || obs_fault !== 0) begin
      n_errors++; $display("FAIL rstmid_after: got lv %0d data %h req %0d fault %0d expected 1 %h 2 0",
        obs_lv, obs_ld, obs_req, obs_fault, rd); end
  endtask

  task automatic test_random();
    op_t o;
    bit  ok;
    int  sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      o = mk(sel < 5 ? LD : (sel < 9 ? ST : 7'($urandom)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1)) o.addr[1:0] = 2'b00;
      if (o.f3 > 5 && $urandom_range(0, 1)) o.f3 = 3'd0;
      ok = m_is_mem(o) && !m_fault(o);
      op_q = '{o};
      run_ops();
      n_checks++;
      if (obs_hung !== 0 || obs_fault !== int'(m_fault(o)) || obs_req !== (ok ? o.waits + 1 : 0) ||
          obs_stall !== (ok ? o.waits + 2 : 0) || obs_unstable !== 0) begin
        n_errors++; $display("FAIL rnd_ctrl[%0d]: op %h f3 %0d addr %h got fault %0d req %0d stall %0d unstable %0d",
          i, o.opc, o.f3, o.addr, obs_fault, obs_req, obs_stall, obs_unstable);
      end
      if (ok) begin
        n_checks++;
        if (obs_addr !== {o.addr[31:2], 2'b00} || obs_be !== m_be(o) || obs_we !== (o.opc == ST)) begin
          n_errors++; $display("FAIL rnd_bus[%0d]: got addr %h be %b we %b expected %h %b %b",
            i, obs_addr, obs_be, obs_we, {o.addr[31:2], 2'b00}, m_be(o), o.opc == ST);
        end
        n_checks++;
        if (o.opc == ST) begin
          if (obs_wdata !== m_wdata(o) || obs_lv !== 0) begin
            n_errors++; $display("FAIL rnd_store[%0d]: got wdata %h lv %0d expected %h 0", i, obs_wdata, obs_lv, m_wdata(o));
          end
        end else if (obs_ld !== m_load(o) || obs_lv !== 1) begin
          n_errors++; $display("FAIL rnd_load[%0d]: f3 %0d addr %h rdata %h got %h lv %0d expected %h 1",
            i, o.f3, o.addr, o.rdata, obs_ld, obs_lv, m_load(o));
        end
      end else begin
        n_checks++;
        if (obs_lv !== 0) begin n_errors++; $display("FAIL rnd_nolv[%0d]: got %0d expected 0", i, obs_lv); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode_i = NOP; funct3_i = '0; addr_i = '0; wdata_i = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    test_reset();
    test_sw_basic();
    test_lb_wait();
    test_lhu_sb();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
